exe_muldiv_iter: RTL

EXE_MULDIV_ITER -- requirements
Module: exe_muldiv_iter

---
 rtl/exe_muldiv_pkg.sv | 36 +++
 rtl/exe_div_step.sv | 21 ++
 rtl/exe_muldiv_iter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_pkg.sv
// Shared op encoding, FSM state encoding and op-class helpers for the
// iterative multiply/divide unit.
package exe_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULHU = 3'd1,
        OP_DIVU  = 3'd2,
        OP_REMU  = 3'd3,
        OP_MULH  = 3'd4,
        OP_DIV   = 3'd5,
        OP_REM   = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op inside {OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Ops whose answer lives in the upper half of the accumulator
    // (high product word, or remainder).
    function automatic logic op_is_upper(input op_e op);
        return op inside {OP_MULHU, OP_REMU, OP_MULH, OP_REM};
    endfunction

endpackage

// File: rtl/exe_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the remainder, trial-subtract the divisor, keep the difference if non-negative.
module exe_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_i};
    assign rem_o   = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH+1]};

endmodule

// File: rtl/exe_muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract per cycle.
// Signed ops 4-6 are built only when MULDIV_SIGNED_EN is defined; otherwise they are reserved.
module exe_muldiv_iter
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             dbz
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 dbz_q, dbz_d;
    op_e                  op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    op_e                  op_in;
    logic                 op_ok;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, div_next, step_next;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic [WIDTH-1:0]     raw_res, fin_res;

    assign op_in = op_e'(op);

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_d, sgn_a, sgn_b, neg_in;
    logic [2*WIDTH-1:0] neg_prod;

    assign op_ok  = (op_in != OP_RSVD);
    assign sgn_a  = op_is_signed(op_in) & a[WIDTH-1];
    assign sgn_b  = op_is_signed(op_in) & b[WIDTH-1];
    assign a_mag  = sgn_a ? -a : a;
    assign b_mag  = sgn_b ? -b : b;
    assign neg_in = (op_in == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
`else
    assign op_ok  = !op_is_signed(op_in) && (op_in != OP_RSVD);
    assign a_mag  = a;
    assign b_mag  = b;
`endif

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: accumulator is {remainder, dividend shifting into quotient}.
    exe_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i     (acc_q[WIDTH-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );
    assign div_next  = {div_rem, div_quo};

    assign step_next = op_is_div(op_q) ? div_next : mul_next;
    assign raw_res   = op_is_upper(op_q) ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];

`ifdef MULDIV_SIGNED_EN
    assign neg_prod = -step_next;
    always_comb begin
        fin_res = raw_res;
        if (neg_q) begin
            fin_res = (op_q == OP_MULH) ? neg_prod[2*WIDTH-1:WIDTH] : -raw_res;
        end
    end
`else
    assign fin_res = raw_res;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
`ifdef MULDIV_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d  = op_in;
                    cnt_d = CNT_W'(WIDTH - 1);
                    if (!op_ok) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        dbz_d    = 1'b0;
                    end else if (op_is_div(op_in) && (b == '0)) begin
                        state_d  = ST_DONE;
                        result_d = op_is_upper(op_in) ? a : '1;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        opnd_d  = op_is_div(op_in) ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op_is_div(op_in) ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
                        neg_d   = neg_in;
`endif
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_next;
                    if (cnt_q == '0) begin
                        state_d  = ST_DONE;
                        result_d = fin_res;
                        dbz_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    // NOTE: datapath registers are left unreset; they are always loaded at acceptance before use.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        opnd_q <= opnd_d;
        acc_q  <= acc_d;
`ifdef MULDIV_SIGNED_EN
        neg_q  <= neg_d;
`endif
    end

    assign ready  = (state_q == ST_IDLE);
    assign valid  = (state_q == ST_DONE);
    assign result = result_q;
    assign dbz    = dbz_q;

endmodule
